// File: rtl/temp_calc_seq.sv
// temp_calc_seq: multi-channel calibrated temperature calculator.
// A sample is accepted in IDLE. Its channel's calibration (base, coef) is
// snapshotted at that edge. The product coef*sense is then built by a
// shift-add multiplier, one sensor bit per cycle with the LSB first. The
// result is base + product, clamped to the output width.
// Optional macro TEMP_AVG_EN: the reported temperature is averaged with the
// previous saturated result of the same channel (per-channel history).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE.
// While DONE waits for out_ready, the outputs hold steady.
module temp_calc_seq #(
    parameter int SENSE_W = 4,
    parameter int COEF_W  = 4,
    parameter int BASE_W  = 8,
    parameter int OUT_W   = 8,
    parameter int NCH     = 4,
    parameter int CH_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cal_we,
    input  logic [CH_W-1:0]   cal_ch,
    input  logic [BASE_W-1:0] cal_base,
    input  logic [COEF_W-1:0] cal_coef,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [SENSE_W-1:0] in_sense,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [OUT_W-1:0]  out_temp,
    output logic              out_sat
);

    localparam int PROD_W = SENSE_W + COEF_W;
    localparam int SUM_W  = ((BASE_W > PROD_W) ? BASE_W : PROD_W) + 1;
    localparam int CMP_W  = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
    localparam int CNT_W  = $clog2(SENSE_W + 1);

    typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_e;

    state_e              state_q, state_d;
    logic [BASE_W-1:0]   cal_base_q [NCH];
    logic [COEF_W-1:0]   cal_coef_q [NCH];
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [PROD_W-1:0]   mcand_q, mcand_d;
    logic [SENSE_W-1:0]  mplier_q, mplier_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;
    logic [OUT_W-1:0]    out_temp_q, out_temp_d;
    logic                out_sat_q, out_sat_d;

    logic                in_ch_ok, cal_ch_ok, ch_ok;
    logic [BASE_W-1:0]   snap_base;
    logic [COEF_W-1:0]   snap_coef;
    logic [SUM_W-1:0]    sum;
    logic [CMP_W-1:0]    sum_wide, max_wide;
    logic                sat;
    logic [OUT_W-1:0]    sat_val, result;

    // Channels beyond NCH have no calibration entry and read back as zero.
    assign in_ch_ok  = 32'(in_ch) < NCH;
    assign cal_ch_ok = 32'(cal_ch) < NCH;
    assign ch_ok     = 32'(ch_q) < NCH;
    assign snap_base = in_ch_ok ? cal_base_q[in_ch] : '0;
    assign snap_coef = in_ch_ok ? cal_coef_q[in_ch] : '0;

    // The sum is compared against the output maximum at a width that can hold both.
    assign sum      = SUM_W'(base_q) + SUM_W'(acc_q);
    assign sum_wide = CMP_W'(sum);
    assign max_wide = {{(CMP_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    assign sat      = sum_wide > max_wide;
    assign sat_val  = sat ? {OUT_W{1'b1}} : OUT_W'(sum_wide);

`ifdef TEMP_AVG_EN
    logic [OUT_W-1:0] hist_q [NCH];
    logic [NCH-1:0]   primed_q;
    logic [OUT_W-1:0] hist_sel;
    logic             primed_sel;
    logic [OUT_W:0]   avg_sum;

    assign hist_sel   = ch_ok ? hist_q[ch_q] : '0;
    assign primed_sel = ch_ok ? primed_q[ch_q] : 1'b0;
    assign avg_sum    = {1'b0, hist_sel} + {1'b0, sat_val};
    assign result     = primed_sel ? avg_sum[OUT_W:1] : sat_val;

    // History updates on the ADD cycle. A calibration write re-arms the channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) hist_q[i] <= '0;
            primed_q <= '0;
        end else begin
            if (state_q == ADD && ch_ok) begin
                hist_q[ch_q]   <= sat_val;
                primed_q[ch_q] <= 1'b1;
            end
            if (cal_we && cal_ch_ok) primed_q[cal_ch] <= 1'b0;
        end
    end
`else
    assign result = sat_val;
`endif

    // Calibration register file. Writes are accepted in every FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cal_base_q[i] <= '0;
                cal_coef_q[i] <= '0;
            end
        end else if (cal_we && cal_ch_ok) begin
            cal_base_q[cal_ch] <= cal_base;
            cal_coef_q[cal_ch] <= cal_coef;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            base_q     <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_ch_q   <= '0;
            out_temp_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            base_q     <= base_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_ch_q   <= out_ch_d;
            out_temp_q <= out_temp_d;
            out_sat_q  <= out_sat_d;
        end
    end

    // Next-state logic: accept, shift-add, saturate, then hold until consumed.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        base_d     = base_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_ch_d   = out_ch_q;
        out_temp_d = out_temp_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = MUL;
                    ch_d     = in_ch;
                    base_d   = snap_base;
                    mcand_d  = PROD_W'(snap_coef);
                    mplier_d = in_sense;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            MUL: begin
                // mcand holds coef << i while bit i of the sample is in mplier[0].
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SENSE_W - 1)) state_d = ADD;
            end
            ADD: begin
                out_temp_d = result;
                out_sat_d  = sat;
                out_ch_d   = ch_q;
                state_d    = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_ch    = out_ch_q;
    assign out_temp  = out_temp_q;
    assign out_sat   = out_sat_q;

endmodule

// File: doc/temp_calc_seq.md
Name: temp_calc_seq

Overview:
- Multi-channel, parametrised successor of the combinational base + sensor × coefficient temperature path.
- Holds a per-channel calibration register file (base temperature, coefficient).
- Each accepted sample is computed with a sequential shift-add multiplier, then a saturating add.
- Sits between the sensor sampling front end and the display/alarm logic, with valid/ready handshakes on both sides.

Parameters:
- SENSE_W, 4, sensor value width.
- COEF_W, 4, calibration coefficient width.
- BASE_W, 8, calibration base temperature width.
- OUT_W, 8, output temperature width.
- NCH, 4, number of channels.
- CH_W, 2, channel index width. Requires 2^CH_W >= NCH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- cal_we  in  1  calibration write strobe.
- cal_ch  in  CH_W  channel being calibrated.
- cal_base  in  BASE_W  base temperature to store.
- cal_coef  in  COEF_W  coefficient to store.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- in_ch  in  CH_W  channel of the offered sample.
- in_sense  in  SENSE_W  raw sensor value.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_ch  out  CH_W  channel of the result.
- out_temp  out  OUT_W  computed temperature.
- out_sat  out  1  result was clamped.

Behaviour:
- Clocking: single clock domain, clk. rst is asynchronous and active-high; everything below is relative to rising edges of clk.
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, out_ch=0, out_temp=0, out_sat=0, all cal_base/cal_coef=0, multiplier registers=0.
- Calibration writes: when cal_we=1, write both fields of channel cal_ch at the edge. This works in any FSM state. cal_ch >= NCH is ignored.
- Sample accept: occurs on an edge where in_valid & in_ready. At that edge:
  - latch in_ch and in_sense;
  - snapshot that channel's cal_base and cal_coef;
  - clear the accumulator.
- Calibration/accept collision: if cal_we targets the same channel on the accept edge, the snapshot takes the OLD values. Later calibration writes never affect an in-flight computation.
- in_ch >= NCH: the sample is accepted and computed with base=0, coef=0.
- in_ready is 1 only in IDLE.
- FSM:
  - IDLE: accept -> MUL, with bit counter = 0.
  - MUL: one multiplier bit per cycle, LSB first. If sense bit i = 1, acc += coef << i. After SENSE_W cycles -> ADD.
  - ADD: one cycle. sum = base + acc, computed at width max(BASE_W, SENSE_W+COEF_W)+1. If sum > 2^OUT_W-1: out_temp = all ones and out_sat=1. Otherwise out_temp = sum and out_sat=0. out_ch = latched channel, out_valid=1 -> DONE.
  - DONE: hold out_valid, out_ch, out_temp and out_sat stable until out_valid & out_ready. On that edge out_valid=0 -> IDLE.
- Latency: accept edge E; out_valid is high after edge E+SENSE_W+1.
- Throughput: with out_ready held high, one sample every SENSE_W+3 cycles.
- Reset asserted mid-operation (any state): return immediately to reset values; the in-flight sample is lost and no partial result is produced.

Optional Feature:
- Macro: TEMP_AVG_EN.
- Defined:
  - Add per-channel history registers plus a per-channel "primed" flag, both cleared on reset.
  - The primed flag is also cleared by a calibration write to that channel.
  - In ADD: compute sat_val, the saturated sum.
  - If the channel is not primed: out_temp = sat_val, history = sat_val, primed = 1.
  - If primed: out_temp = (history + sat_val) >> 1, computed at OUT_W+1 bits and rounded down; history = sat_val.
  - out_sat reflects only the current sample.
  - Latency is unchanged.
- Not defined: no history storage; out_temp = sat_val.

Test Plan:
- Basic result and latency: cal ch1 base=25, coef=3; sample ch1 sense=10 -> out_temp=55, out_ch=1, out_sat=0; out_valid rises 5 edges after the accept edge; in_ready=0 throughout.
- Saturation: cal ch0 base=200, coef=15; sense=15 (sum 425) -> out_temp=255, out_sat=1.
- Output backpressure: hold out_ready=0 for 4 cycles after out_valid -> outputs stable, in_ready=0, a second in_valid is not accepted. Raise out_ready -> handshake completes, next sample is accepted in IDLE.
- Calibration during computation: accept ch2 with base=10, coef=2, sense=5; during MUL write ch2 base=100 -> result 20. A following sample ch2 sense=5 -> 110.
- Reset mid-MUL: assert rst two cycles into MUL -> out_valid stays 0, in_ready=1 immediately, calibration cleared; a new sample on ch1 sense=10 -> out_temp=0.
- TEMP_AVG_EN averaging: ch1 base=25, coef=3; sense=10 -> 55, then sense=2 (31) -> 43. Calibration write to ch1, then sense=2 -> 31 (unprimed pass-through).
